// File: rtl/spi_slave_io.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_io
// Description : SPI mode-0 responder with a one-byte receive buffer and a
//               one-byte transmit holding register, exposed to the CPU IO
//               space as strobe/flag ports. All pin inputs are synchronized
//               into the clk domain and edge-detected there.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   MSB_FIRST  1 = bit 7 first on the wire, 0 = bit 0 first
//   FILL       byte shifted out when no transmit byte is waiting at byte start
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   sck, ss, mosi       asynchronous SPI pins from the external master
//   miso, miso_oe       slave data out and its tristate enable
//   tx_data, tx_load    CPU write of the transmit holding register
//   tx_full             holding register occupied
//   rx_data, rx_full    last received byte and its unread flag
//   rx_rd               CPU acknowledges rx_data
//   err_clr             clears the sticky error flags
//   rx_ovr, tx_udr      sticky receive-overrun / transmit-underrun flags
// ============================================================================
module spi_slave_io #(
    parameter int         MSB_FIRST = 1,
    parameter logic [7:0] FILL      = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sck,
    input  logic       ss,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_full,
    output logic [7:0] rx_data,
    output logic       rx_full,
    input  logic       rx_rd,
    input  logic       err_clr,
    output logic       rx_ovr,
    output logic       tx_udr
);

    localparam logic [1:0] c_wait_idle = 2'd0;
    localparam logic [1:0] c_idle      = 2'd1;
    localparam logic [1:0] c_active    = 2'd2;

    // Pin pipelines: [0] first sync flop, [1] second sync flop, [2] history.
    logic [2:0] r_sck_p;
    logic [2:0] r_ss_p;
    logic [2:0] r_mosi_p;
    logic       r_sck_rise;
    logic       r_sck_fall;
    logic       r_ss_fall;
    logic       r_ss_rise;
    // Fills with ones after reset; the history flops only reflect the real
    // pins once it is full, so WAIT_IDLE must not trust the reset value of ss.
    logic [2:0] r_warm;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;

    logic [2:0] r_bit_cnt;
    logic [6:0] r_rx_sr;
    logic [7:0] r_tx_sr;
    logic       r_need_start;
    logic [7:0] r_tx_hold;
    logic       r_tx_full;
    logic [7:0] r_rx_data;
    logic       r_rx_full;
    logic       r_rx_ovr;
    logic       r_tx_udr;

    logic       w_active;
    logic       w_byte_start;
    logic       w_shift;
    logic       w_rx_bit;
    logic       w_abort;
    logic       w_byte_done;
    logic       w_consume;
    logic       w_mosi;
    logic [7:0] w_rx_byte;
    logic [6:0] w_rx_shift;
    logic [7:0] w_tx_shifted;
    logic       w_tx_bit;

    // ------------------------------------------------------------------
    // Synchronizers and registered edge detectors. The mosi history flop
    // lines up with the registered sck edge pulses, so the bit sampled on
    // a detected rise is the one present at the matching pin edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sck_p    <= 3'b000;
            r_ss_p     <= 3'b111;
            r_mosi_p   <= 3'b000;
            r_sck_rise <= 1'b0;
            r_sck_fall <= 1'b0;
            r_ss_fall  <= 1'b0;
            r_ss_rise  <= 1'b0;
            r_warm     <= 3'b000;
        end else begin
            r_sck_p    <= {r_sck_p[1:0], sck};
            r_ss_p     <= {r_ss_p[1:0], ss};
            r_mosi_p   <= {r_mosi_p[1:0], mosi};
            r_sck_rise <=  r_sck_p[1] & ~r_sck_p[2];
            r_sck_fall <= ~r_sck_p[1] &  r_sck_p[2];
            r_ss_fall  <= ~r_ss_p[1]  &  r_ss_p[2];
            r_ss_rise  <=  r_ss_p[1]  & ~r_ss_p[2];
            r_warm     <= {r_warm[1:0], 1'b1};
        end
    end

    assign w_mosi = r_mosi_p[2];

    // ------------------------------------------------------------------
    // Bit-order dependent shift paths. The receive register holds only
    // seven bits; the eighth goes straight into the assembled byte.
    // ------------------------------------------------------------------
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_rx_byte    = {r_rx_sr, w_mosi};
            assign w_rx_shift   = {r_rx_sr[5:0], w_mosi};
            assign w_tx_shifted = {r_tx_sr[6:0], 1'b0};
            assign w_tx_bit     = r_tx_sr[7];
        end else begin : g_lsb_first
            assign w_rx_byte    = {w_mosi, r_rx_sr};
            assign w_rx_shift   = {w_mosi, r_rx_sr[6:1]};
            assign w_tx_shifted = {1'b0, r_tx_sr[7:1]};
            assign w_tx_bit     = r_tx_sr[0];
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_wait_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_wait_idle: if (r_warm[2] && r_ss_p[2]) w_state_nxt = c_idle;
            c_idle:      if (r_ss_fall)              w_state_nxt = c_active;
            c_active:    if (r_ss_rise)              w_state_nxt = c_idle;
            default:                                 w_state_nxt = c_wait_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs / datapath controls. Deselect wins over any sck edge
    // seen in the same cycle, so a frame ending on the final sck fall
    // does not start a phantom byte.
    // ------------------------------------------------------------------
    always_comb begin
        w_active     = (r_state == c_active);
        w_byte_start = 1'b0;
        w_shift      = 1'b0;
        w_rx_bit     = 1'b0;
        w_abort      = 1'b0;
        if (r_state == c_idle && r_ss_fall) begin
            w_byte_start = 1'b1;
        end else if (w_active) begin
            if (r_ss_rise) begin
                w_abort = 1'b1;
            end else begin
                w_rx_bit = r_sck_rise;
                if (r_sck_fall) begin
                    w_byte_start = r_need_start;
                    w_shift      = ~r_need_start;
                end
            end
        end
    end

    assign w_byte_done = w_rx_bit && (r_bit_cnt == 3'd7);
    assign w_consume   = w_byte_start && r_tx_full;

    // ------------------------------------------------------------------
    // Shift registers and bit counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_cnt    <= 3'd0;
            r_rx_sr      <= 7'd0;
            r_tx_sr      <= 8'd0;
            r_need_start <= 1'b0;
        end else begin
            if (w_rx_bit) begin
                r_rx_sr   <= w_rx_shift;
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (w_byte_done) begin
                    r_need_start <= 1'b1;
                end
            end
            if (w_byte_start) begin
                r_need_start <= 1'b0;
                r_tx_sr      <= r_tx_full ? r_tx_hold : FILL;
            end else if (w_shift) begin
                r_tx_sr <= w_tx_shifted;
            end
            if (w_abort) begin
                r_bit_cnt    <= 3'd0;
                r_rx_sr      <= 7'd0;
                r_tx_sr      <= 8'd0;
                r_need_start <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // CPU-side registers and sticky flags. A load is accepted when the
    // holding register is free or is being consumed this very cycle; a
    // read coincident with completion frees the buffer for the new byte.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_hold <= 8'd0;
            r_tx_full <= 1'b0;
            r_rx_data <= 8'd0;
            r_rx_full <= 1'b0;
            r_rx_ovr  <= 1'b0;
            r_tx_udr  <= 1'b0;
        end else begin
            if (tx_load && (!r_tx_full || w_consume)) begin
                r_tx_hold <= tx_data;
                r_tx_full <= 1'b1;
            end else if (w_consume) begin
                r_tx_full <= 1'b0;
            end

            if (w_byte_start && !r_tx_full) begin
                r_tx_udr <= 1'b1;
            end else if (err_clr) begin
                r_tx_udr <= 1'b0;
            end

            if (w_byte_done && (!r_rx_full || rx_rd)) begin
                r_rx_data <= w_rx_byte;
                r_rx_full <= 1'b1;
            end else if (rx_rd) begin
                r_rx_full <= 1'b0;
            end

            if (w_byte_done && r_rx_full && !rx_rd) begin
                r_rx_ovr <= 1'b1;
            end else if (err_clr) begin
                r_rx_ovr <= 1'b0;
            end
        end
    end

    assign miso    = w_active & w_tx_bit;
    assign miso_oe = w_active;
    assign tx_full = r_tx_full;
    assign rx_data = r_rx_data;
    assign rx_full = r_rx_full;
    assign rx_ovr  = r_rx_ovr;
    assign tx_udr  = r_tx_udr;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_io.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave_io
// Description : Self-checking bench for spi_slave_io. Drives an SPI master
//               at clk/8 and a CPU port; one instance is MSB-first, a second
//               LSB-first instance shares all inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_io;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       sck     = 1'b0;
    logic       ss      = 1'b1;
    logic       mosi    = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_load = 1'b0;
    logic       rx_rd   = 1'b0;
    logic       err_clr = 1'b0;

    logic       miso_m, oe_m, txf_m, rxf_m, ovr_m, udr_m;
    logic [7:0] rxd_m;
    logic       miso_l, oe_l, txf_l, rxf_l, ovr_l, udr_l;
    logic [7:0] rxd_l;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb_q[$];

    typedef struct {
        logic [7:0] tx;
        bit         load;
        logic [7:0] mo;
        logic [7:0] exp_miso;
        bit         exp_udr;
    } vec_t;

    always #5 clk = ~clk;

    spi_slave_io #(.MSB_FIRST(1), .FILL(8'hFF)) dut_m (
        .clk(clk), .reset(reset), .sck(sck), .ss(ss), .mosi(mosi),
        .miso(miso_m), .miso_oe(oe_m), .tx_data(tx_data), .tx_load(tx_load),
        .tx_full(txf_m), .rx_data(rxd_m), .rx_full(rxf_m), .rx_rd(rx_rd),
        .err_clr(err_clr), .rx_ovr(ovr_m), .tx_udr(udr_m)
    );

    spi_slave_io #(.MSB_FIRST(0), .FILL(8'hFF)) dut_l (
        .clk(clk), .reset(reset), .sck(sck), .ss(ss), .mosi(mosi),
        .miso(miso_l), .miso_oe(oe_l), .tx_data(tx_data), .tx_load(tx_load),
        .tx_full(txf_l), .rx_data(rxd_l), .rx_full(rxf_l), .rx_rd(rx_rd),
        .err_clr(err_clr), .rx_ovr(ovr_l), .tx_udr(udr_l)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_check(input string name, input logic [7:0] act);
        logic [7:0] e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got %0h expected <nothing queued>", name, act);
        end else begin
            e = sb_q.pop_front();
            chk(name, act, e);
        end
    endtask

    task automatic do_load(input logic [7:0] d);
        @(negedge clk); tx_data = d; tx_load = 1'b1;
        @(negedge clk); tx_load = 1'b0;
    endtask

    task automatic do_rd();
        @(negedge clk); rx_rd = 1'b1;
        @(negedge clk); rx_rd = 1'b0;
    endtask

    task automatic do_clr();
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
    endtask

    task automatic ss_low();
        @(negedge clk); ss = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    // Sends nbits of mo; when end_frame the final sck fall and ss rise coincide.
    // mode 1: check rx_full latency around the 8th rise; mode 2: rx_rd pulse
    // in the completion cycle.
    task automatic xfer(input logic [7:0] mo, input bit lsb, input int nbits,
                        input bit end_frame, input int mode,
                        output logic [7:0] mi_m, output logic [7:0] mi_l);
        mi_m = 8'h00;
        mi_l = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = lsb ? mo[i] : mo[7-i];
            repeat (4) @(negedge clk);
            mi_m[7-i] = miso_m;
            mi_l[i]   = miso_l;
            sck = 1'b1;
            if (i == 7 && mode == 1) begin
                repeat (3) @(negedge clk);
                chk("rx_full_before_done", rxf_m, 0);
                @(negedge clk);
                chk("rx_full_after_done", rxf_m, 1);
            end else if (i == 7 && mode == 2) begin
                repeat (3) @(negedge clk);
                rx_rd = 1'b1;
                @(negedge clk);
                rx_rd = 1'b0;
            end else begin
                repeat (4) @(negedge clk);
            end
            sck = 1'b0;
            if (end_frame && i == nbits - 1) ss = 1'b1;
        end
    endtask

    task automatic frame1(input logic [7:0] mo, input int mode, output logic [7:0] mi_m);
        logic [7:0] ml;
        ss_low();
        xfer(mo, 1'b0, 8, 1'b1, mode, mi_m, ml);
        repeat (8) @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_miso"},    miso_m, 0);
        chk({tag, "_miso_oe"}, oe_m,   0);
        chk({tag, "_tx_full"}, txf_m,  0);
        chk({tag, "_rx_data"}, rxd_m,  8'h00);
        chk({tag, "_rx_full"}, rxf_m,  0);
        chk({tag, "_rx_ovr"},  ovr_m,  0);
        chk({tag, "_tx_udr"},  udr_m,  0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vt[4];
        logic [7:0] mm, ml;

        vt[0] = '{tx: 8'hA5, load: 1'b1, mo: 8'h3C, exp_miso: 8'hA5, exp_udr: 1'b0};
        vt[1] = '{tx: 8'h00, load: 1'b0, mo: 8'h55, exp_miso: 8'hFF, exp_udr: 1'b1};
        vt[2] = '{tx: 8'h5A, load: 1'b1, mo: 8'hF0, exp_miso: 8'h5A, exp_udr: 1'b0};
        vt[3] = '{tx: 8'h0F, load: 1'b1, mo: 8'h00, exp_miso: 8'h0F, exp_udr: 1'b0};

        // Reset state
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset("rst");
        chk("rst_l_oe", oe_l, 0);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("idle_oe", oe_m, 0);

        // Single-byte frames from the table
        for (int v = 0; v < 4; v++) begin
            do_rd();
            do_clr();
            if (vt[v].load) begin
                do_load(vt[v].tx);
                chk("vec_tx_full_loaded", txf_m, 1);
            end
            sb_q.push_back(vt[v].exp_miso);
            ss_low();
            chk("vec_miso_oe_active", oe_m, 1);
            xfer(vt[v].mo, 1'b0, 8, 1'b1, 1, mm, ml);
            repeat (8) @(negedge clk);
            sb_check("vec_miso_byte", mm);
            chk("vec_rx_data",   rxd_m, vt[v].mo);
            chk("vec_rx_full",   rxf_m, 1);
            chk("vec_tx_full",   txf_m, 0);
            chk("vec_tx_udr",    udr_m, vt[v].exp_udr);
            chk("vec_rx_ovr",    ovr_m, 0);
            chk("vec_oe_off",    oe_m,  0);
            chk("vec_miso_idle", miso_m, 0);
        end

        // Second load while full is ignored
        do_rd();
        do_clr();
        do_load(8'h11);
        do_load(8'h22);
        sb_q.push_back(8'h11);
        frame1(8'h00, 0, mm);
        sb_check("load_ignored_miso", mm);

        // Two-byte frame, second byte underruns and overruns the rx buffer
        do_rd();
        do_clr();
        do_load(8'hC3);
        sb_q.push_back(8'hC3);
        sb_q.push_back(8'hFF);
        ss_low();
        xfer(8'hAA, 1'b0, 8, 1'b0, 0, mm, ml);
        sb_check("two_byte0_miso", mm);
        xfer(8'h55, 1'b0, 8, 1'b1, 0, mm, ml);
        repeat (8) @(negedge clk);
        sb_check("two_byte1_miso", mm);
        chk("two_tx_udr",  udr_m, 1);
        chk("two_rx_data", rxd_m, 8'hAA);
        chk("two_rx_ovr",  ovr_m, 1);
        do_clr();
        chk("errclr_tx_udr", udr_m, 0);
        chk("errclr_rx_ovr", ovr_m, 0);

        // Overrun, then read coincident with completion
        do_rd();
        frame1(8'h11, 1, mm);
        frame1(8'h22, 0, mm);
        chk("ovr_rx_data", rxd_m, 8'h11);
        chk("ovr_rx_ovr",  ovr_m, 1);
        chk("ovr_rx_full", rxf_m, 1);
        do_clr();
        frame1(8'h22, 2, mm);
        chk("rdcoin_rx_data", rxd_m, 8'h22);
        chk("rdcoin_rx_full", rxf_m, 1);
        chk("rdcoin_rx_ovr",  ovr_m, 0);

        // Frame aborted after 5 bits; holding byte survives for the next frame
        do_rd();
        do_clr();
        ss_low();
        do_load(8'h7E);
        xfer(8'hFF, 1'b0, 5, 1'b1, 0, mm, ml);
        repeat (8) @(negedge clk);
        chk("abort_rx_full", rxf_m, 0);
        chk("abort_tx_full", txf_m, 1);
        chk("abort_oe",      oe_m,  0);
        sb_q.push_back(8'h7E);
        ss_low();
        xfer(8'h81, 1'b0, 8, 1'b1, 1, mm, ml);
        repeat (8) @(negedge clk);
        sb_check("abort_next_miso", mm);
        chk("abort_next_rx_data", rxd_m, 8'h81);
        chk("abort_next_tx_full", txf_m, 0);

        // Reset in the middle of a frame with ss held low
        do_load(8'h99);
        ss_low();
        xfer(8'hFF, 1'b0, 3, 1'b0, 0, mm, ml);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_reset("midrst");
        reset = 1'b0;
        repeat (4) @(negedge clk);
        xfer(8'hFF, 1'b0, 3, 1'b0, 0, mm, ml);
        repeat (6) @(negedge clk);
        chk("midrst_no_rx_full", rxf_m, 0);
        chk("midrst_no_oe",      oe_m,  0);
        chk("midrst_rx_data",    rxd_m, 8'h00);
        ss = 1'b1;
        repeat (8) @(negedge clk);
        sb_q.push_back(8'hFF);
        frame1(8'h5A, 1, mm);
        sb_check("midrst_miso", mm);
        chk("midrst_rx_data_new", rxd_m, 8'h5A);

        // LSB-first instance
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        do_load(8'h01);
        sb_q.push_back(8'h01);
        ss_low();
        xfer(8'h80, 1'b1, 8, 1'b1, 0, mm, ml);
        repeat (8) @(negedge clk);
        chk("lsb_first_bit", ml[0], 1);
        sb_check("lsb_miso", ml);
        chk("lsb_rx_data", rxd_l, 8'h80);
        chk("lsb_rx_full", rxf_l, 1);
        chk("lsb_tx_full", txf_l, 0);

        chk("sb_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_slave_io.md
# spi_slave_io

SPI mode-0 slave (responder) with a single-byte receive buffer and single-byte transmit holding register, presented to the light8080 IO space as simple strobe/flag ports. It is the peripheral-side counterpart of the SoC's SPI master: an external SPI master drives `sck`/`ss`/`mosi`, and the CPU exchanges bytes through IO registers. All pin inputs are asynchronous. They are synchronized and edge-detected in the single system clock domain, so no cross-domain handshake is required.

## Interface
Parameters:
- MSB_FIRST, 1, bit order on the wire (1 = bit 7 first, 0 = bit 0 first)
- FILL, 8'hFF, byte shifted out when the transmit holding register is empty at byte start

Ports:
- clk  in  1  system clock; SPI `sck` must not exceed clk/8
- reset  in  1  synchronous, active-high
- sck  in  1  SPI clock from master, asynchronous
- ss  in  1  slave select, active low, asynchronous
- mosi  in  1  master-out data, asynchronous
- miso  out  1  slave-out data
- miso_oe  out  1  tristate enable for miso; 1 while selected
- tx_data  in  8  byte to transmit
- tx_load  in  1  one-cycle strobe; writes tx_data into the holding register
- tx_full  out  1  holding register occupied
- rx_data  out  8  last received byte
- rx_full  out  1  rx_data holds an unread byte
- rx_rd  in  1  one-cycle strobe; CPU consumed rx_data
- err_clr  in  1  one-cycle strobe; clears sticky errors
- rx_ovr  out  1  sticky: a byte was received while rx_full=1
- tx_udr  out  1  sticky: a byte started while the holding register was empty

## Operation
- Input sync: 2-flop synchronizer plus one history flop each for sck, ss and mosi. Sync/history flops reset to sck=0, ss=1, mosi=0. Edges: sck_rise, sck_fall, ss_fall, ss_rise are single-cycle pulses from the synced and history values.
- FSM states: WAIT_IDLE, IDLE, ACTIVE. Reset enters WAIT_IDLE.
  - WAIT_IDLE -> IDLE when synced ss=1. This prevents joining a frame that is already in progress.
  - IDLE -> ACTIVE on ss_fall.
  - ACTIVE -> IDLE on ss_rise, from any bit position.
- Byte start, on entry to ACTIVE and on the first sck_fall after a completed byte:
  - tx shift register <= holding register if tx_full=1, and tx_full clears. Otherwise it loads FILL and tx_udr sets.
  - miso drives the first bit (bit 7 if MSB_FIRST, else bit 0).
- ACTIVE, sck_rise: shift synced mosi into the rx shift register and increment a 3-bit bit counter. On the 8th rise (counter wraps 7->0), the byte is complete.
- ACTIVE, sck_fall not at byte start: shift tx register and drive the next bit on miso.
- Byte complete:
  - If rx_full=0: rx_data <= assembled byte and rx_full <= 1.
  - If rx_full=1: the new byte is dropped, rx_data is unchanged, and rx_ovr <= 1.
  - Exception: if rx_rd occurs in the same cycle, the old byte counts as consumed, the new byte is stored, rx_full stays 1, and there is no overrun.
- tx_load:
  - Ignored when tx_full=1; the holding register is not overwritten.
  - Accepted if tx_full=1 but the holding register is consumed by a byte start in the same cycle. The new data is written and tx_full stays 1.
- ss_rise mid-byte: the partial rx byte is discarded with no flag change, the bit counter clears, and the tx shift contents are discarded. The holding register is kept unless it was already consumed.
- miso_oe = 1 only in ACTIVE. miso = 0 when not ACTIVE.
- err_clr clears rx_ovr and tx_udr. A set event in the same cycle wins.
- rx_rd with rx_full=0: no effect.

## Timing
- Reset values: miso=0, miso_oe=0, tx_full=0, rx_data=8'h00, rx_full=0, rx_ovr=0, tx_udr=0. Shift registers and bit counter are 0.
- Pin-to-detect latency: 3 clk cycles (2 sync + 1 edge register) for every sck/ss edge.
- rx_full/rx_data update in the clk cycle after sck_rise is detected for the 8th bit.
- The first miso bit is valid 1 clk after ss_fall is detected (4 clk after the ss pin falls). The master must allow at least 5 clk between ss falling and the first sck rise.
- Each subsequent miso bit changes 1 clk after sck_fall is detected.
- Mode 0 only: mosi is sampled at detected sck rise, and the mosi synchronizer tracks sck's delay, so mosi is sampled at the matching edge.
- All status outputs are registered. tx_full drops in the same cycle the shift register loads.

## Test plan
- MSB_FIRST=1, CPU tx_load 8'hA5, master frame sends 8'h3C at clk/8 -> miso bits 1,0,1,0,0,1,0,1; rx_data=8'h3C, rx_full=1 one clk after the 8th detected rise; tx_full=0; no errors.
- Two-byte frame, second tx_load skipped -> second byte out is 8'hFF, tx_udr=1; err_clr -> tx_udr=0.
- Receive 8'h11 without rx_rd, then 8'h22 -> rx_data stays 8'h11, rx_ovr=1. Repeat with rx_rd coincident with the completion cycle -> rx_data=8'h22, rx_ovr=0.
- ss deasserted after 5 bits, then a full frame of 8'h81 -> only one rx_full event, rx_data=8'h81; the unconsumed holding byte is transmitted in the new frame.
- Reset asserted mid-frame with ss held low, then 3 more sck pulses, then ss high, then a new frame 8'h5A -> outputs at reset values, no capture until ss is seen high, then rx_data=8'h5A.
- MSB_FIRST=0, tx 8'h01, rx 8'h80 sent LSB-first -> miso first bit 1, rx_data=8'h80.
